fifo_pkt_drain: RTL

// - Read-side consumer for the 16x32 first-word-fall-through FIFOs: pops 32-bit words, frames them into packets, emits valid/ready stream.
// - Head data is valid whenever empty=0; a pop is i_fifo_rd_en=1 with empty=0.
// - Header word carries the payload length; output marks sop/eop. Sits between a link-side FIFO and the router/NI input port.
//

---
 rtl/fifo_pkt_drain_pkg.sv | 16 +
 rtl/fifo_pkt_drain_if.sv | 27 ++
 rtl/fifo_skid2.sv | 59 +++++
 rtl/fifo_pkt_drain.sv | 107 ++++++++++
 4 files changed

// File: rtl/fifo_pkt_drain_pkg.sv
// rtl/fifo_pkt_drain_pkg.sv - shared defaults and framing state for the packet drain
package fifo_pkt_drain_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_LEN_LSB = 0;
  localparam int DEF_LEN_W   = 5;
  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_CNT_W   = 16;

  // Encodings are shared with other stream adapters that decode the state.
  typedef enum logic {
    ST_HDR  = 1'b0,
    ST_BODY = 1'b1
  } drain_state_e;

endpackage

// File: rtl/fifo_pkt_drain_if.sv
// rtl/fifo_pkt_drain_if.sv - FWFT FIFO read side plus framed output stream
interface fifo_pkt_drain_if
  import fifo_pkt_drain_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [DATA_W-1:0] fifo_data;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              sop;
  logic              eop;
  logic              ready;

  modport master (
    input  fifo_data, fifo_empty, ready,
    output fifo_rd_en, data, valid, sop, eop
  );

  modport slave (
    output fifo_data, fifo_empty, ready,
    input  fifo_rd_en, data, valid, sop, eop
  );

endinterface

// File: rtl/fifo_skid2.sv
// rtl/fifo_skid2.sv - two-entry registered skid buffer with flopped has_space
module fifo_skid2 #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         has_space,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic [1:0]   count_next;
  logic         push;
  logic         pop;

  assign push      = in_valid & has_space;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // has_space is a flop so the upstream pop never depends on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      has_space <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count     <= count_next;
      has_space <= (count_next != 2'd2);
    end
  end

endmodule

// File: rtl/fifo_pkt_drain.sv
// rtl/fifo_pkt_drain.sv - pops FWFT FIFO words, frames them by header length, emits sop/eop stream
module fifo_pkt_drain
  import fifo_pkt_drain_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LEN_LSB = DEF_LEN_LSB,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_pkt_drain_if.master     bus,
  output logic                 err_len,
  output logic [CNT_W-1:0]     pkt_cnt
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

  drain_state_e     state;
  drain_state_e     state_next;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] rem_next;
  logic [LEN_W-1:0] hdr_len;
  logic             has_space;
  logic             pop;
  logic             tag_sop;
  logic             tag_eop;
  logic             len_bad;

  assign pop            = ~bus.fifo_empty & has_space & ~rst;
  assign bus.fifo_rd_en = pop;
  assign hdr_len        = bus.fifo_data[LEN_LSB +: LEN_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_HDR;
      rem   <= '0;
    end else begin
      state <= state_next;
      rem   <= rem_next;
    end
  end

  // Tags describe the current FIFO head; they only matter on a pop.
  always_comb begin
    state_next = state;
    rem_next   = rem;
    tag_sop    = 1'b0;
    tag_eop    = 1'b0;
    len_bad    = 1'b0;
    case (state)
      ST_HDR: begin
        tag_sop = 1'b1;
        tag_eop = (hdr_len == '0);
        if (pop) begin
          len_bad = (hdr_len > MAX_LEN_L);
          if (hdr_len != '0) begin
            rem_next   = hdr_len;
            state_next = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        tag_eop = (rem == ONE_L);
        if (pop) begin
          rem_next = rem - ONE_L;
          if (rem == ONE_L) begin
            state_next = ST_HDR;
          end
        end
      end
      default: begin
        state_next = ST_HDR;
      end
    endcase
  end

  fifo_skid2 #(
    .W(DATA_W + 2)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({tag_sop, tag_eop, bus.fifo_data}),
    .in_valid  (pop),
    .has_space (has_space),
    .out_data  ({bus.sop, bus.eop, bus.data}),
    .out_valid (bus.valid),
    .out_ready (bus.ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err_len <= 1'b0;
      pkt_cnt <= '0;
    end else begin
      if (len_bad) begin
        err_len <= 1'b1;
      end
      if (bus.valid & bus.ready & bus.eop) begin
        pkt_cnt <= pkt_cnt + CNT_W'(1);
      end
    end
  end

endmodule
